// File: rtl/aadd_err_stats.sv
// Error statistics for an approximate adder: compares exact and approximate sums over a
// window of N_SAMPLES accepted samples, tracking mismatch count, max and saturating sum of |diff|.
module aadd_err_stats #(
   parameter int unsigned N_SAMPLES = 1024,
   parameter int unsigned SUM_W     = 48
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      exact_i,
   input  logic [31:0]      approx_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [31:0]      sample_count_o,
   output logic [31:0]      err_count_o,
   output logic [31:0]      max_abs_err_o,
   output logic [SUM_W-1:0] sum_abs_err_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic               accept, clear, last;
   logic signed [32:0] diff;
   logic [31:0]        abs_err;
   logic [SUM_W:0]     sum_ext;

   logic [31:0]        sample_count_q, sample_count_d;
   logic [31:0]        err_count_q, err_count_d;
   logic [31:0]        max_abs_err_q, max_abs_err_d;
   logic [SUM_W-1:0]   sum_abs_err_q, sum_abs_err_d;

   assign accept = (state_q == StRun) && in_valid_i;
   assign clear  = (state_q != StRun) && start_i;
   assign last   = (sample_count_q == 32'(N_SAMPLES - 1));

   // 33-bit difference cannot overflow, so its magnitude always fits in 32 bits
   assign diff    = $signed({exact_i[31], exact_i}) - $signed({approx_i[31], approx_i});
   assign abs_err = diff[32] ? 32'(-diff) : diff[31:0];
   assign sum_ext = {1'b0, sum_abs_err_q} + {{(SUM_W + 1 - 32){1'b0}}, abs_err};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i) state_d = StRun;
         StRun:   if (accept && last) state_d = StDone;
         StDone:  if (start_i) state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o     = (state_q == StRun);
      done_o     = (state_q == StDone);
      in_ready_o = (state_q == StRun);
   end

   always_comb begin
      sample_count_d = sample_count_q;
      err_count_d    = err_count_q;
      max_abs_err_d  = max_abs_err_q;
      sum_abs_err_d  = sum_abs_err_q;
      if (clear) begin
         sample_count_d = '0;
         err_count_d    = '0;
         max_abs_err_d  = '0;
         sum_abs_err_d  = '0;
      end else if (accept) begin
         sample_count_d = sample_count_q + 32'd1;
         if (diff != '0) err_count_d = err_count_q + 32'd1;
         if (abs_err > max_abs_err_q) max_abs_err_d = abs_err;
         // Once saturated every further add carries out, so the all-ones value holds
         sum_abs_err_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sample_count_q <= '0;
         err_count_q    <= '0;
         max_abs_err_q  <= '0;
         sum_abs_err_q  <= '0;
      end else begin
         sample_count_q <= sample_count_d;
         err_count_q    <= err_count_d;
         max_abs_err_q  <= max_abs_err_d;
         sum_abs_err_q  <= sum_abs_err_d;
      end
   end

   assign sample_count_o = sample_count_q;
   assign err_count_o    = err_count_q;
   assign max_abs_err_o  = max_abs_err_q;
   assign sum_abs_err_o  = sum_abs_err_q;

endmodule

// File: tb/tb_aadd_err_stats.sv
// Bench for aadd_err_stats with N_SAMPLES=4, SUM_W=33: vector table plus a stall/window sequence,
// each vector's expected post-edge outputs queued at drive time and compared after the edge.
module tb_aadd_err_stats;

   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_ready, busy, done;
   logic [31:0] exact, approx, sample_count, err_count, max_abs_err;
   logic [32:0] sum_abs_err;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        rst, start, valid;
      logic [31:0] ex, ap;
      logic        busy, done, rdy;
      logic [31:0] sc, ec, mx;
      logic [32:0] sum;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   aadd_err_stats #(
      .N_SAMPLES(4),
      .SUM_W    (33)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .exact_i       (exact),
      .approx_i      (approx),
      .busy_o        (busy),
      .done_o        (done),
      .sample_count_o(sample_count),
      .err_count_o   (err_count),
      .max_abs_err_o (max_abs_err),
      .sum_abs_err_o (sum_abs_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic s, input logic vl,
                               input logic [31:0] ex, input logic [31:0] ap,
                               input logic b, input logic d, input logic rd,
                               input logic [31:0] sc, input logic [31:0] ec,
                               input logic [31:0] mx, input logic [32:0] sum);
      vec_t t;
      t.rst = r; t.start = s; t.valid = vl; t.ex = ex; t.ap = ap;
      t.busy = b; t.done = d; t.rdy = rd; t.sc = sc; t.ec = ec; t.mx = mx; t.sum = sum;
      return t;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input int idx);
      vec_t e;
      @(negedge clk);
      rst = t.rst; start = t.start; in_valid = t.valid; exact = t.ex; approx = t.ap;
      sb.push_back(t);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
      end else begin
         e = sb.pop_front();
         chk("busy", idx, 64'(busy), 64'(e.busy));
         chk("done", idx, 64'(done), 64'(e.done));
         chk("in_ready", idx, 64'(in_ready), 64'(e.rdy));
         chk("sample_count", idx, 64'(sample_count), 64'(e.sc));
         chk("err_count", idx, 64'(err_count), 64'(e.ec));
         chk("max_abs_err", idx, 64'(max_abs_err), 64'(e.mx));
         chk("sum_abs_err", idx, 64'(sum_abs_err), 64'(e.sum));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; exact = '0; approx = '0;

      //                 rst start vld exact          approx         b  d  r  sc ec mx            sum
      tbl.push_back(mk(1, 0, 0, 32'd0,        32'd0,        0, 0, 0, 0, 0, 0,            0));
      tbl.push_back(mk(0, 1, 1, 32'd9,        32'd1,        1, 0, 1, 0, 0, 0,            0));
      tbl.push_back(mk(0, 0, 1, 32'd10,       32'd10,       1, 0, 1, 1, 0, 0,            0));
      tbl.push_back(mk(0, 0, 1, 32'd5,        32'd7,        1, 0, 1, 2, 1, 2,            2));
      tbl.push_back(mk(0, 0, 0, 32'd0,        32'd1000,     1, 0, 1, 2, 1, 2,            2));
      tbl.push_back(mk(0, 1, 0, 32'd0,        32'd1000,     1, 0, 1, 2, 1, 2,            2));
      tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFD, 32'd1,        1, 0, 1, 3, 2, 4,            6));
      tbl.push_back(mk(0, 0, 1, 32'd100,      32'd96,       0, 1, 0, 4, 3, 4,            10));
      tbl.push_back(mk(0, 0, 1, 32'd1,        32'd50,       0, 1, 0, 4, 3, 4,            10));
      tbl.push_back(mk(0, 0, 0, 32'd0,        32'd0,        0, 1, 0, 4, 3, 4,            10));
      // start in DONE with a valid sample: cleared, sample not taken
      tbl.push_back(mk(0, 1, 1, 32'd7,        32'd0,        1, 0, 1, 0, 0, 0,            0));
      tbl.push_back(mk(0, 0, 1, 32'h7FFFFFFF, 32'h80000000, 1, 0, 1, 1, 1, 32'hFFFFFFFF,
                       33'h0FFFFFFFF));
      tbl.push_back(mk(0, 0, 1, 32'h80000000, 32'h7FFFFFFF, 1, 0, 1, 2, 2, 32'hFFFFFFFF,
                       33'h1FFFFFFFE));
      tbl.push_back(mk(0, 0, 1, 32'h80000000, 32'h7FFFFFFF, 1, 0, 1, 3, 3, 32'hFFFFFFFF,
                       33'h1FFFFFFFF));
      tbl.push_back(mk(0, 0, 1, 32'd5,        32'd2,        0, 1, 0, 4, 4, 32'hFFFFFFFF,
                       33'h1FFFFFFFF));
      tbl.push_back(mk(0, 0, 0, 32'd0,        32'd0,        0, 1, 0, 4, 4, 32'hFFFFFFFF,
                       33'h1FFFFFFFF));
      // mid-window reset, with start and a valid sample competing on the same edge
      tbl.push_back(mk(0, 1, 0, 32'd0,        32'd0,        1, 0, 1, 0, 0, 0,            0));
      tbl.push_back(mk(0, 0, 1, 32'd1,        32'd2,        1, 0, 1, 1, 1, 1,            1));
      tbl.push_back(mk(0, 0, 1, 32'd2,        32'd2,        1, 0, 1, 2, 1, 1,            1));
      tbl.push_back(mk(1, 1, 1, 32'd9,        32'd0,        0, 0, 0, 0, 0, 0,            0));
      tbl.push_back(mk(0, 0, 1, 32'd9,        32'd0,        0, 0, 0, 0, 0, 0,            0));
      tbl.push_back(mk(0, 1, 0, 32'd0,        32'd0,        1, 0, 1, 0, 0, 0,            0));
      tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 32'd1,        1, 0, 1, 1, 1, 2,            2));

      foreach (tbl[i]) apply(tbl[i], i);

      // long stall inside the window, then finish it
      for (int k = 0; k < 8; k++) begin
         apply(mk(0, 0, 0, 32'($urandom), 32'($urandom), 1, 0, 1, 1, 1, 2, 2), 100 + k);
      end
      apply(mk(0, 0, 1, 32'd3, 32'd0, 1, 0, 1, 2, 2, 3, 5), 200);
      apply(mk(0, 0, 1, 32'd0, 32'd0, 1, 0, 1, 3, 2, 3, 5), 201);
      apply(mk(0, 0, 1, 32'd0, 32'd7, 0, 1, 0, 4, 3, 7, 12), 202);
      apply(mk(0, 0, 0, 32'd0, 32'd0, 0, 1, 0, 4, 3, 7, 12), 203);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
